// File: rtl/pixel_map_scanner.sv
// Frame-scan initiator: walks destination pixels in raster order, asks pixel_map for the source
// coordinate, copies the source pixel (or BLANK when out of frame) into the destination frame.
//
// state    | meaning
// IDLE     | waiting for start
// ISSUE    | present current (x,y) to pixel_map, load settle timer
// SETTLE   | let pixel_map settle, map_ready ignored
// WAIT_MAP | wait for map_ready, bounds-check and latch source address
// READ     | hold src_addr for RD_LAT cycles, then capture src_data
// WRITE    | one destination write strobe
// NEXT     | advance raster position or finish the frame
module pixel_map_scanner #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int PIX_W  = 12,
  parameter int SETTLE = 4,
  parameter int RD_LAT = 2,
  parameter logic [PIX_W-1:0] BLANK = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [9:0]          map_x,
  output logic [8:0]          map_y,
  input  logic [9:0]          map_ox,
  input  logic [8:0]          map_oy,
  input  logic signed [36:0]  map_ox_signed,
  input  logic signed [36:0]  map_oy_signed,
  input  logic                map_ready,
  output logic [18:0]         src_addr,
  input  logic [PIX_W-1:0]    src_data,
  output logic [18:0]         dst_addr,
  output logic [PIX_W-1:0]    dst_data,
  output logic                dst_we
);

  localparam int CNT_MAX = (SETTLE > RD_LAT) ? SETTLE : RD_LAT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [9:0]         X_LAST  = 10'(H_RES - 1);
  localparam logic [8:0]         Y_LAST  = 9'(V_RES - 1);
  localparam logic [18:0]        H_MUL   = 19'(H_RES);
  localparam logic signed [36:0] H_LIM   = 37'(H_RES);
  localparam logic signed [36:0] V_LIM   = 37'(V_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT_MAP,
    S_READ,
    S_WRITE,
    S_NEXT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             last_pix;
  logic             in_frame;
  logic [18:0]      src_calc;
  logic [18:0]      dst_calc;

  assign last_pix = (map_x == X_LAST) && (map_y == Y_LAST);

  // Full-width signed compare so negative or huge mapped values never alias into the frame.
  assign in_frame = (map_ox_signed >= 37'sd0) && (map_ox_signed < H_LIM) &&
                    (map_oy_signed >= 37'sd0) && (map_oy_signed < V_LIM);

  assign src_calc = 19'(map_oy) * H_MUL + 19'(map_ox);
  assign dst_calc = 19'(map_y) * H_MUL + 19'(map_x);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (start) state_nx = S_ISSUE;
      S_ISSUE:    state_nx = (SETTLE == 0) ? S_WAIT_MAP : S_SETTLE;
      S_SETTLE:   if (cnt == CNT_ONE) state_nx = S_WAIT_MAP;
      S_WAIT_MAP: if (map_ready) state_nx = in_frame ? S_READ : S_WRITE;
      S_READ:     if (cnt == CNT_ONE) state_nx = S_WRITE;
      S_WRITE:    state_nx = S_NEXT;
      S_NEXT:     state_nx = last_pix ? S_IDLE : S_ISSUE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE) && !((state == S_NEXT) && last_pix);
    done   = (state == S_NEXT) && last_pix;
    dst_we = (state == S_WRITE);
  end

  // map_x/map_y only move on the edge into ISSUE, so they are stable for the whole pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_x    <= '0;
      map_y    <= '0;
      cnt      <= '0;
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        map_x <= '0;
        map_y <= '0;
      end else if ((state == S_NEXT) && !last_pix) begin
        if (map_x == X_LAST) begin
          map_x <= '0;
          map_y <= map_y + 9'd1;
        end else begin
          map_x <= map_x + 10'd1;
        end
      end

      case (state)
        S_ISSUE: cnt <= CNT_W'(SETTLE);
        S_SETTLE: cnt <= cnt - CNT_ONE;
        S_WAIT_MAP: begin
          if (map_ready) begin
            if (in_frame) begin
              src_addr <= src_calc;
              cnt      <= CNT_W'(RD_LAT);
            end else begin
              dst_data <= BLANK;
              dst_addr <= dst_calc;
            end
          end
        end
        S_READ: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            dst_data <= src_data;
            dst_addr <= dst_calc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_map_scanner.sv
// Self-checking bench for pixel_map_scanner on a 4x3 frame: directed and randomized mappings
// checked against a per-pixel timing/data reference model.
module tb_pixel_map_scanner;

  localparam int H        = 4;
  localparam int V        = 3;
  localparam int NPIX     = H * V;
  localparam int PW       = 12;
  localparam int SETTLE_C = 4;
  localparam int RD       = 2;
  localparam logic [PW-1:0] BLANK_C = 12'hABC;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [9:0]        map_x;
  logic [8:0]        map_y;
  logic [9:0]        map_ox;
  logic [8:0]        map_oy;
  logic signed [36:0] map_ox_signed;
  logic signed [36:0] map_oy_signed;
  logic              map_ready;
  logic [18:0]       src_addr;
  logic [PW-1:0]     src_data;
  logic [18:0]       dst_addr;
  logic [PW-1:0]     dst_data;
  logic              dst_we;

  pixel_map_scanner #(
    .H_RES(H), .V_RES(V), .PIX_W(PW), .SETTLE(SETTLE_C), .RD_LAT(RD), .BLANK(BLANK_C)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .map_x(map_x), .map_y(map_y), .map_ox(map_ox), .map_oy(map_oy),
    .map_ox_signed(map_ox_signed), .map_oy_signed(map_oy_signed), .map_ready(map_ready),
    .src_addr(src_addr), .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data),
    .dst_we(dst_we)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-pixel behaviour of the pixel_map model
  logic signed [36:0] ox_t [NPIX];
  logic signed [36:0] oy_t [NPIX];
  int                 dly  [NPIX];

  logic [18:0]   wq_addr[$];
  logic [PW-1:0] wq_data[$];
  int            wq_cyc [$];
  logic [18:0]   wq_src [$];
  logic [18:0]   wq_xy  [$];

  int   done_cnt      = 0;
  int   done_cyc      = -1;
  logic done_busy     = 1'b0;
  int   busy_rise_cyc = -1;
  int   moves_bad     = 0;
  int   rc            = 0;
  logic prev_we       = 1'b0;
  logic prev_busy     = 1'b0;
  logic [9:0] pmx     = '0;
  logic [8:0] pmy     = '0;
  int   model_src     = 0;

  function automatic logic [PW-1:0] src_fn(input logic [18:0] a);
    return PW'(a) ^ 12'h5A0;
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Source BRAM: data for an address is sampled by the scanner RD_LAT edges after it was issued.
  always @(posedge clock) src_data <= src_fn(src_addr);

  // pixel_map responder and write monitor; rc counts cycles since the current pixel's ISSUE.
  always @(negedge clock) begin
    int pix;
    if (!reset_n) begin
      rc        = 0;
      prev_we   = 1'b0;
      prev_busy = 1'b0;
      map_ready = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        rc = 0;
        busy_rise_cyc = cyc;
      end else if (prev_we) begin
        rc = -1;
      end else begin
        rc = rc + 1;
      end
      if (busy && rc != 0 && (map_x != pmx || map_y != pmy)) moves_bad++;
      pix = int'(map_y) * H + int'(map_x);
      if (pix >= NPIX) pix = 0;
      map_ox_signed = ox_t[pix];
      map_oy_signed = oy_t[pix];
      map_ox        = ox_t[pix][9:0];
      map_oy        = oy_t[pix][8:0];
      map_ready     = busy && (rc >= dly[pix]);
      if (dst_we) begin
        wq_addr.push_back(dst_addr);
        wq_data.push_back(dst_data);
        wq_cyc.push_back(cyc);
        wq_src.push_back(src_addr);
        wq_xy.push_back({map_y, map_x});
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      prev_we   = dst_we;
      prev_busy = busy;
    end
    pmx = map_x;
    pmy = map_y;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic gen_identity();
    for (int k = 0; k < NPIX; k++) begin
      ox_t[k] = 37'(k % H);
      oy_t[k] = 37'(k / H);
      dly[k]  = 3;
    end
  endtask

  task automatic gen_random();
    for (int k = 0; k < NPIX; k++) begin
      dly[k]  = int'($urandom_range(0, 9));
      ox_t[k] = 37'($urandom_range(0, H - 1));
      oy_t[k] = 37'($urandom_range(0, V - 1));
      case ($urandom_range(0, 9))
        0: ox_t[k] = -37'sd1;
        1: ox_t[k] = 37'(H);
        2: oy_t[k] = 37'(V);
        3: oy_t[k] = {1'b1, 36'd2};
        4: ox_t[k] = 37'h0_8000_0000;
        default: ;
      endcase
    end
  endtask

  function automatic logic in_frame_ref(input int k);
    return (ox_t[k] >= 0) && (ox_t[k] < H) && (oy_t[k] >= 0) && (oy_t[k] < V);
  endfunction

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_src.delete(); wq_xy.delete();
    done_cnt = 0; done_cyc = -1; moves_bad = 0; busy_rise_cyc = -1;
  endtask

  task automatic run_frame(input string name, input int extra_start);
    int s, issue, e, w, last_w, exp_src, n;
    logic inf;
    @(posedge clock);
    clear_mon();
    @(negedge clock);
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock);
      if (done_cnt != 0) break;
      @(negedge clock);
      start = (i == extra_start);
    end
    start = 1'b0;
    repeat (20) @(posedge clock);

    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_busy_rise"}, busy_rise_cyc, s + 1);
    chk({name, "_writes"}, wq_addr.size(), NPIX);
    issue = s + 1;
    last_w = 0;
    exp_src = model_src;
    n = (wq_addr.size() < NPIX) ? wq_addr.size() : NPIX;
    for (int k = 0; k < NPIX; k++) begin
      inf = in_frame_ref(k);
      e = issue + (((1 + SETTLE_C) > dly[k]) ? (1 + SETTLE_C) : dly[k]);
      w = e + 1 + (inf ? RD : 0);
      if (inf) exp_src = int'(oy_t[k]) * H + int'(ox_t[k]);
      if (k < n) begin
        chk($sformatf("%s_addr%0d", name, k), wq_addr[k], k);
        chk($sformatf("%s_data%0d", name, k), wq_data[k],
            inf ? src_fn(19'(exp_src)) : BLANK_C);
        chk($sformatf("%s_wcyc%0d", name, k), wq_cyc[k], w);
        chk($sformatf("%s_src%0d", name, k), wq_src[k], exp_src);
        chk($sformatf("%s_xy%0d", name, k), wq_xy[k], {9'(k / H), 10'(k % H)});
      end
      issue = w + 2;
      last_w = w;
    end
    model_src = exp_src;
    chk({name, "_done_cyc"}, done_cyc, last_w + 1);
    chk({name, "_done_busy"}, done_busy, 1'b0);
    chk({name, "_coord_moves"}, moves_bad, 0);
    chk({name, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic reached;
    reset_n = 1'b0;
    start   = 1'b0;
    gen_identity();
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", dst_we, 1'b0);
    chk("rst_map_x", map_x, 0);
    chk("rst_map_y", map_y, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_dst_addr", dst_addr, 0);
    chk("rst_dst_data", dst_data, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    gen_identity();
    run_frame("identity", -1);

    gen_identity();
    for (int k = 0; k < NPIX; k += H) ox_t[k] = -37'sd1;
    run_frame("x0_neg", -1);

    gen_identity();
    for (int k = 0; k < NPIX; k++) oy_t[k] = 37'(V);
    run_frame("oy_eq_v", -1);

    gen_random();
    dly[1 * H + 2] = 55;
    run_frame("stall", -1);

    gen_random();
    run_frame("restart", 30);

    for (int f = 0; f < 3; f++) begin
      gen_random();
      run_frame($sformatf("rand%0d", f), (f == 1) ? 70 : -1);
    end

    // Abort mid-frame during pixel (1,1)
    gen_identity();
    @(posedge clock);
    clear_mon();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (map_x == 10'd1 && map_y == 9'd1) begin
        reached = 1'b1;
        break;
      end
    end
    chk("abort_reached_1_1", reached, 1'b1);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_we", dst_we, 1'b0);
    chk("abort_map_x", map_x, 0);
    chk("abort_map_y", map_y, 0);
    chk("abort_src_addr", src_addr, 0);
    chk("abort_dst_addr", dst_addr, 0);
    chk("abort_dst_data", dst_data, 0);
    chk("abort_partial_writes", wq_addr.size(), H + 1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_src = 0;
    repeat (30) @(posedge clock);
    chk("abort_no_done", done_cnt, 0);

    gen_identity();
    run_frame("after_abort", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
